mod7_tx: RTL and testbench

MOD7_TX -- requirements
Module: mod7_tx

---
 rtl/mod7_tx.sv | 99 +++++++++
 tb/tb_mod7_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mod7_tx.sv
// mod7_tx: serialises DATA_W-bit words MSB first, each followed by 3 check bits making the frame divisible by 7
// Ports: clk/rst (async, active-high); data_in/data_valid/data_ready accept a word;
// ser_out/ser_valid carry the frame, sof/eof mark its first/last bit, busy flags a frame in progress.
module mod7_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy
);
  // the check phase counts to 2, so the counter never drops below 2 bits even for DATA_W=2
  localparam int CW = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [2:0] r_q, r_d, r_next, chk_c;
  logic [3:0] r2, r_sub;
  logic ser_out_q, ser_out_d, ser_valid_q, ser_valid_d, sof_q, sof_d, eof_q, eof_d;
  logic last_data, last_chk, hs;
  // 2r+b is just {r,b}; one conditional subtract of 7 keeps it in 0..6
  assign r2 = {r_q, sh_q[DATA_W-1]};
  assign r_sub = r2 - 4'd7;
  assign r_next = (r2 >= 4'd7) ? r_sub[2:0] : r2[2:0];
  assign chk_c = (r_q == 3'd0) ? 3'd0 : 3'd7 - r_q;
  assign last_data = (state_q == DATA) && (cnt_q == CW'(DATA_W - 1));
  assign last_chk = (state_q == CHECK) && (cnt_q == CW'(2));
  assign data_ready = (state_q == IDLE) || last_chk;
  assign hs = data_valid && data_ready;
  assign busy = (state_q != IDLE);
  assign ser_out = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign sof = sof_q;
  assign eof = eof_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    sh_d = sh_q;
    r_d = r_q;
    ser_out_d = 1'b0;
    ser_valid_d = 1'b0;
    sof_d = 1'b0;
    eof_d = 1'b0;
    if (state_q == IDLE || last_chk) begin
      state_d = hs ? DATA : IDLE;
      cnt_d = '0;
      if (hs) begin
        sh_d = {data_in[DATA_W-2:0], 1'b0};
        r_d = {2'b00, data_in[DATA_W-1]};
        ser_out_d = data_in[DATA_W-1];
        ser_valid_d = 1'b1;
        sof_d = 1'b1;
      end
    end else if (state_q == DATA) begin
      ser_valid_d = 1'b1;
      if (last_data) begin
        state_d = CHECK;
        cnt_d = '0;
        ser_out_d = chk_c[2];
      end else begin
        ser_out_d = sh_q[DATA_W-1];
        sh_d = {sh_q[DATA_W-2:0], 1'b0};
        r_d = r_next;
      end
    end else begin
      ser_valid_d = 1'b1;
      ser_out_d = (cnt_q == '0) ? chk_c[1] : chk_c[0];
      eof_d = (cnt_q == CW'(1));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      r_q <= '0;
      ser_out_q <= 1'b0;
      ser_valid_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      r_q <= r_d;
      ser_out_q <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
    end
  end
endmodule

// File: tb/tb_mod7_tx.sv
// tb_mod7_tx: random and directed frames checked by a divide-by-7 receiver model
module tb_mod7_tx;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, data_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic data_ready, ser_out, ser_valid, sof, eof, busy;
  int checks = 0, errors = 0;
  longint unsigned expq[$];
  longint unsigned rx = 0, last_rx = 0, expw;
  int n = 0, rem = 0, run = 0, last_run = 0;
  logic hs_prev = 1'b0;
  mod7_tx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .sof(sof), .eof(eof), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // receiver model: rebuilds each frame and divides it by 7
  task automatic mon();
    if (hs_prev) chk("latency_sof", {ser_valid, sof}, 2'b11);
    chk("ready", data_ready, !ser_valid || eof);
    chk("busy", busy, ser_valid);
    if (!ser_valid) begin
      chk("idle_out", {ser_out, sof, eof}, 3'b000);
      chk("frame_gap", n, 0);
      if (run > 0) last_run = run;
      run = 0;
    end else begin
      run++;
      chk("sof", sof, n == 0);
      if (n == 0) begin
        rx = 0;
        rem = 0;
      end
      rx = (rx << 1) | ser_out;
      rem = (2 * rem + int'(ser_out)) % 7;
      n++;
      chk("eof", eof, n == W + 3);
      if (n == W + 3) begin
        chk("rem", rem, 0);
        chk("word_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          expw = expq.pop_front();
          chk("frame", rx, expw * 8 + (7 - expw % 7) % 7);
        end
        last_rx = rx;
        n = 0;
      end
    end
  endtask
  task automatic step(input logic dv, input logic [W-1:0] d);
    @(negedge clk);
    mon();
    data_valid = dv;
    data_in = d;
    #1;
    hs_prev = dv && data_ready && !rst;
    if (hs_prev) expq.push_back(longint'(d));
  endtask
  task automatic send(input logic [W-1:0] d);
    int k = 0;
    do begin
      step(1'b1, d);
      k++;
    end while (!hs_prev && k < 40);
    if (!hs_prev) chk("hs_timeout", 0, 1);
  endtask
  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(1'b0, W'($urandom));
  endtask
  initial begin
    data_valid = 1'b1;
    data_in = 8'h01;
    #12;
    chk("rst_out", {ser_out, ser_valid, sof, eof, busy}, 5'b0);
    chk("rst_ready", data_ready, 1);
    #11 rst = 1'b0;
    data_valid = 1'b0;
    idle(2);
    send(8'h01); idle(W + 5);
    chk("d01", last_rx, 64'h00E);
    send(8'hFF); idle(W + 5);
    chk("dff", last_rx, 64'h7FC);
    send(8'h00); idle(W + 5);
    chk("d00_chk", last_rx & 7, 0);
    send(8'h07); idle(W + 5);
    chk("d07", last_rx, 64'h038);
    send(8'h01); send(8'hFF); idle(W + 5);
    chk("b2b_run", last_run, 22);
    send(8'hA5);
    for (int k = 0; k < 20 && n < 4; k++) step(1'b0, 8'h5A);
    chk("abort_pos", n, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {ser_out, ser_valid, sof, eof, busy}, 5'b0);
    chk("rst_ready_mid", data_ready, 1);
    expq.delete();
    n = 0;
    run = 0;
    hs_prev = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h77;
    repeat (2) @(negedge clk);
    chk("rst_hold", {ser_valid, busy}, 2'b00);
    #2 data_valid = 1'b0;
    rst = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    send(8'h03); idle(W + 5);
    chk("d03", last_rx, 64'h01C);
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      while ($urandom_range(0, 9) < 3) step(1'b0, W'($urandom));
      send(w);
    end
    idle(W + 5);
    chk("drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
